// File: rtl/rx_drop_buffer.sv
// Store-and-forward receive buffer: frames are forwarded only once complete and error-free.
// Optional frame statistics outputs are enabled with RX_DROP_BUFFER_STATS_EN.
module rx_drop_buffer #(
  parameter int DATA_W     = 32,
  parameter int EMPTY_W    = 2,
  parameter int ERR_W      = 6,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic [ERR_W-1:0]   in_error,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               drop_pulse
`ifdef RX_DROP_BUFFER_STATS_EN
  ,
  output logic [31:0]        frames_ok,
  output logic [31:0]        frames_dropped
`endif
);

  localparam int PTR_W  = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int WORD_W = 2 + EMPTY_W + DATA_W;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  wr_state_t         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              out_valid_q, out_valid_d;
  logic              drop_q, drop_d;
  logic              in_ready_q;

  logic              accept, restart, store, full, mem_we, rd_en;
  logic [PTR_W-1:0]  base_ptr;

  // A sop inside RECV abandons the partial frame, so the new frame is placed at commit_ptr.
  always_comb begin
    accept   = in_valid && in_ready_q;
    restart  = accept && in_sop && (state_q == RECV);
    base_ptr = restart ? commit_ptr_q : wr_ptr_q;
    full     = (base_ptr - rd_ptr_q) == PTR_FULL;
    store    = accept && (in_sop || (state_q == RECV));

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = 1'b0;
    mem_we       = 1'b0;

    if (accept && (state_q == DISCARD) && !in_sop && in_eop) begin
      state_d = IDLE;
    end

    if (store) begin
      drop_d = restart;
      if (full) begin
        wr_ptr_d = commit_ptr_q;
        drop_d   = 1'b1;
        state_d  = in_eop ? IDLE : DISCARD;
      end else begin
        mem_we = 1'b1;
        if (!in_eop) begin
          wr_ptr_d = base_ptr + PTR_ONE;
          state_d  = RECV;
        end else if (in_error == '0) begin
          wr_ptr_d     = base_ptr + PTR_ONE;
          commit_ptr_d = base_ptr + PTR_ONE;
          state_d      = IDLE;
        end else begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
          state_d  = IDLE;
        end
      end
    end
  end

  // Output register doubles as the RAM read register, so it refills in the cycle it drains.
  always_comb begin
    rd_en       = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || out_ready);
    rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    if (rd_en) begin
      out_word_d  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[base_ptr[DEPTH_LOG2-1:0]] <= {in_sop, in_eop, in_empty, in_data};
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_word_q   <= '0;
      out_valid_q  <= 1'b0;
      drop_q       <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_word_q   <= out_word_d;
      out_valid_q  <= out_valid_d;
      drop_q       <= drop_d;
      in_ready_q   <= 1'b1;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_word_q[WORD_W-1];
  assign out_eop    = out_word_q[WORD_W-2];
  assign out_empty  = out_word_q[DATA_W +: EMPTY_W];
  assign out_data   = out_word_q[DATA_W-1:0];
  assign drop_pulse = drop_q;

`ifdef RX_DROP_BUFFER_STATS_EN
  logic [31:0] frames_ok_q, frames_ok_d;
  logic [31:0] frames_dropped_q, frames_dropped_d;

  // A commit is the only event that moves commit_ptr; both counters saturate.
  always_comb begin
    frames_ok_d      = frames_ok_q;
    frames_dropped_d = frames_dropped_q;
    if ((commit_ptr_d != commit_ptr_q) && (frames_ok_q != '1)) begin
      frames_ok_d = frames_ok_q + 32'd1;
    end
    if (drop_d && (frames_dropped_q != '1)) begin
      frames_dropped_d = frames_dropped_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
    end else begin
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;
`endif

endmodule
